draftname_uart_tx: RTL and testbench

Serial UART transmitter for the draftname tile. It accepts one byte per valid/ready handshake and shifts it out LSB-first on a single pin as an 8N1 frame, or 8E1 when parity is compiled in. It is the off-chip transmit end for results computed in the tile's datapath: the top level feeds it bytes and routes `tx_out` to an output pin, so an external UART receiver can capture them.

---
 rtl/draftname_pkg.sv | 17 +
 rtl/draftname_baud_gen.sv | 26 ++
 rtl/draftname_uart_tx.sv | 124 ++++++++++++
 tb/tb_draftname_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/draftname_pkg.sv
// Shared types and frame constants for the draftname UART transmitter.
// The PARITY state is only reachable when DRAFTNAME_TX_PARITY_EN is defined.
package draftname_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam int   STOP_BITS = 1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/draftname_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit-time with a one-cycle bit_done pulse.
module draftname_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  logic [CNT_W-1:0] cnt;

  assign bit_done = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_done ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/draftname_uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB-first as 8N1,
// or 8E1 when DRAFTNAME_TX_PARITY_EN is defined. All outputs are registered.
module draftname_uart_tx
  import draftname_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy
);

  tx_state_t  state, state_next;
  logic [7:0] shreg, shreg_next;
  logic [2:0] bit_idx;
  logic       bit_done;
  logic       hs;
  logic       tx_out_d, tx_ready_d, busy_d;
`ifdef DRAFTNAME_TX_PARITY_EN
  logic       parity_bit;
`endif

  assign hs = tx_valid && tx_ready;

  draftname_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (hs),
    .en      (state != IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else begin
      state <= state_next;
      if (hs) begin
        bit_idx <= '0;
      end else if (state == DATA && bit_done) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (hs) state_next = START;
      START:  if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done && bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef DRAFTNAME_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef DRAFTNAME_TX_PARITY_EN
      PARITY: if (bit_done) state_next = STOP;
`endif
      STOP:   if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift register is data only: loaded on handshake, never reset.
  always_comb begin
    shreg_next = shreg;
    if (hs) begin
      shreg_next = tx_data;
    end else if (state == DATA && bit_done) begin
      shreg_next = {1'b0, shreg[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_next;
`ifdef DRAFTNAME_TX_PARITY_EN
    if (hs) begin
      parity_bit <= ^tx_data;
    end
`endif
  end

  // Outputs are computed from next-state values so the registers line up
  // with the state they describe.
  always_comb begin
    tx_out_d   = LINE_IDLE;
    tx_ready_d = (state_next == IDLE);
    busy_d     = (state_next != IDLE);
    case (state_next)
      START:  tx_out_d = 1'b0;
      DATA:   tx_out_d = shreg_next[0];
`ifdef DRAFTNAME_TX_PARITY_EN
      PARITY: tx_out_d = parity_bit;
`endif
      default: tx_out_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_out   <= LINE_IDLE;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      tx_out   <= tx_out_d;
      tx_ready <= tx_ready_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_draftname_uart_tx.sv
// Directed self-checking bench for draftname_uart_tx with CLKS_PER_BIT=4;
// expected frames adapt to DRAFTNAME_TX_PARITY_EN.
module tb_draftname_uart_tx;

  localparam int CPB = 4;
`ifdef DRAFTNAME_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_out, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  draftname_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .busy    (busy)
  );

  // Expected line level for frame bit j: start, 8 data LSB-first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[3'(j - 1)];
    if (FB == 11 && j == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d: tx_out=%b tx_ready=%b busy=%b, expected 1 1 0",
                 i, tx_out, tx_ready, busy);
      end
    end
    rst_n = 1'b1;
    step();
    tx_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx_ready !== 1'b0 || tx_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_handshake: busy=%b tx_ready=%b tx_out=%b, expected 1 0 0",
               busy, tx_ready, tx_out);
    end
    for (int i = 0; i < CPB * FB; i++) begin
      checks++;
      if (tx_out !== exp_bit(8'h55, i / CPB) || busy !== 1'b1 || tx_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_frame cyc=%0d: tx_out=%b busy=%b tx_ready=%b, expected %b 1 0",
                 i, tx_out, busy, tx_ready, exp_bit(8'h55, i / CPB));
      end
      step();
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_frame_end: tx_ready=%b busy=%b tx_out=%b, expected 1 0 1",
               tx_ready, busy, tx_out);
    end
  endtask

  task automatic test_single_byte();
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < CPB * FB; i++) begin
      checks++;
      if (tx_out !== exp_bit(8'hA5, i / CPB) || busy !== 1'b1 || tx_ready !== 1'b0) begin
        failures++;
        $display("FAIL single_a5 cyc=%0d: tx_out=%b busy=%b tx_ready=%b, expected %b 1 0",
                 i, tx_out, busy, tx_ready, exp_bit(8'hA5, i / CPB));
      end
      step();
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL single_a5_end: tx_ready=%b busy=%b tx_out=%b, expected 1 0 1",
               tx_ready, busy, tx_out);
    end
  endtask

  task automatic test_late_data();
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    step();
    tx_valid = 1'b0;
    tx_data = 8'hFF;
    for (int i = 0; i < CPB * FB; i++) begin
      checks++;
      if (tx_out !== exp_bit(8'h3C, i / CPB)) begin
        failures++;
        $display("FAIL late_data cyc=%0d: tx_out=%b, expected %b",
                 i, tx_out, exp_bit(8'h3C, i / CPB));
      end
      step();
    end
    tx_data = 8'h00;
  endtask

  task automatic test_back_to_back();
    tx_valid = 1'b1;
    tx_data = 8'h00;
    step();
    tx_data = 8'hFF;
    for (int i = 0; i < CPB * FB; i++) begin
      checks++;
      if (tx_out !== exp_bit(8'h00, i / CPB) || tx_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_first cyc=%0d: tx_out=%b tx_ready=%b, expected %b 0",
                 i, tx_out, tx_ready, exp_bit(8'h00, i / CPB));
      end
      step();
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: tx_ready=%b busy=%b tx_out=%b, expected 1 0 1",
               tx_ready, busy, tx_out);
    end
    step();
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1 || tx_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_start: tx_ready=%b busy=%b tx_out=%b, expected 0 1 0",
               tx_ready, busy, tx_out);
    end
    for (int i = 0; i < CPB * FB; i++) begin
      checks++;
      if (tx_out !== exp_bit(8'hFF, i / CPB) || tx_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_second cyc=%0d: tx_out=%b tx_ready=%b, expected %b 0",
                 i, tx_out, tx_ready, exp_bit(8'hFF, i / CPB));
      end
      step();
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: tx_ready=%b busy=%b, expected 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    tx_valid = 1'b1;
    tx_data = 8'h00;
    step();
    tx_valid = 1'b0;
    // Run into the middle of data bit 3 (frame bit 4).
    for (int i = 0; i < 4 * CPB + 2; i++) begin
      checks++;
      if (tx_out !== exp_bit(8'h00, i / CPB) || busy !== 1'b1) begin
        failures++;
        $display("FAIL midrst_pre cyc=%0d: tx_out=%b busy=%b, expected %b 1",
                 i, tx_out, busy, exp_bit(8'h00, i / CPB));
      end
      step();
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort: tx_out=%b tx_ready=%b busy=%b, expected 1 1 0",
               tx_out, tx_ready, busy);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle: tx_out=%b tx_ready=%b busy=%b, expected 1 1 0",
               tx_out, tx_ready, busy);
    end
    tx_valid = 1'b1;
    tx_data = 8'h96;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < CPB * FB; i++) begin
      checks++;
      if (tx_out !== exp_bit(8'h96, i / CPB) || busy !== 1'b1) begin
        failures++;
        $display("FAIL midrst_fresh cyc=%0d: tx_out=%b busy=%b, expected %b 1",
                 i, tx_out, busy, exp_bit(8'h96, i / CPB));
      end
      step();
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL midrst_fresh_end: tx_ready=%b busy=%b tx_out=%b, expected 1 0 1",
               tx_ready, busy, tx_out);
    end
  endtask

  initial begin
    test_reset();
    step();
    test_single_byte();
    step();
    test_late_data();
    step();
    test_back_to_back();
    step();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
